fir_sample_ingress: RTL and testbench

Input stage directly upstream of the FIR filter. Takes the 6-bit sample and strobe from the dedicated input pins, synchronises them, detects each strobe rising edge, and buffers one sample per edge in a small FIFO. The FIFO head drives the FIR's AXI-stream slave port (`s_axis_fir_tdata` / `tvalid` / `tready`) through a valid/ready handshake, so the FIR never sees metastable or repeated samples.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_sync_fifo.sv | 61 ++++++
 rtl/fir_sample_ingress.sv | 99 +++++++++
 tb/tb_fir_sample_ingress.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: sample widths, the sample type and a pointer-width helper.
package fir_pkg;

  localparam int FIR_IN_W  = 6;
  localparam int FIR_OUT_W = 8;

  typedef logic [FIR_IN_W-1:0] fir_sample_t;

  // Pointer width for a power-of-two FIFO: one extra MSB separates full from empty.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Generic DEPTH x DATA_W synchronous FIFO.
// Read data is zero while empty. A push into a full FIFO is accepted only when a
// pop happens in the same cycle. The pointers carry one extra MSB and wrap modulo 2*DEPTH.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_IN_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W-1:0]  w_level;
  logic              w_wr_en;
  logic              w_rd_en;

  assign w_level = r_wptr - r_rptr;
  assign o_empty = (w_level == '0);
  assign o_full  = (w_level == FULL_LVL);
  assign o_level = w_level;
  assign w_rd_en = i_pop & ~o_empty;
  // When full, the slot being written is the one leaving through the pop in this cycle.
  assign w_wr_en = i_push & (~o_full | w_rd_en);
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[IDX_W-1:0]];

  // Read and write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wptr[IDX_W-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/fir_sample_ingress.sv
// Pin-side ingress for the FIR: synchronises the sample and strobe pins, turns each
// strobe rising edge into one FIFO push, and presents the FIFO head as an
// AXI-stream master. Optional drop counter: define FIR_INGRESS_OVF_CNT_EN.
module fir_sample_ingress
  import fir_pkg::*;
#(
  parameter int DATA_W      = FIR_IN_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      pin_data,
  input  logic                   pin_strobe,
  input  logic                   clr_ovf,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             ovf_count
);

  logic [DATA_W-1:0]      r_data_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_strb_sync;
  logic                   r_strb_d;
  logic                   r_overflow;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;
  logic [DATA_W-1:0]      w_sample;

  // Synchroniser chains for data and strobe (same depth keeps them aligned), plus the strobe history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
      r_strb_sync <= '0;
      r_strb_d    <= 1'b0;
    end else begin
      r_data_sync[0] <= pin_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
      r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], pin_strobe};
      r_strb_d    <= r_strb_sync[SYNC_STAGES-1];
    end
  end

  assign w_push   = r_strb_sync[SYNC_STAGES-1] & ~r_strb_d;
  assign w_sample = r_data_sync[SYNC_STAGES-1];
  assign m_axis_tvalid = ~w_empty;
  assign w_pop    = m_axis_tvalid & m_axis_tready;
  assign w_drop   = w_push & w_full & ~w_pop;

  fir_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_sample),
    .o_rdata (m_axis_tdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Sticky overflow flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (clr_ovf) r_overflow <= 1'b0;
  end

  assign overflow = r_overflow;

`ifdef FIR_INGRESS_OVF_CNT_EN
  logic [7:0] r_ovf_count;

  // Saturating drop counter; a drop during a clear restarts the count at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (w_drop) begin
      if (clr_ovf)                r_ovf_count <= 8'd1;
      else if (r_ovf_count != '1) r_ovf_count <= r_ovf_count + 8'd1;
    end else if (clr_ovf) begin
      r_ovf_count <= '0;
    end
  end

  assign ovf_count = r_ovf_count;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_fir_sample_ingress.sv
module tb_fir_sample_ingress;
  import fir_pkg::*;

  localparam int DEPTH = 4;
`ifdef FIR_INGRESS_OVF_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  fir_sample_t       pin_data;
  logic              pin_strobe;
  logic              clr_ovf;
  fir_sample_t       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [2:0]        level;
  logic              overflow;
  logic [7:0]        ovf_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int pops0;
  int exp_q[$];

  fir_sample_ingress #(
    .DATA_W      (FIR_IN_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pin_data      (pin_data),
    .pin_strobe    (pin_strobe),
    .clr_ovf       (clr_ovf),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .level         (level),
    .overflow      (overflow),
    .ovf_count     (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One strobe pulse (2 high, 2 low); the sample is queued as expected output if it will be kept
  task automatic send(input int d, input bit keep);
    pin_data = fir_sample_t'(d);
    tick(1);
    pin_strobe = 1'b1;
    if (keep) exp_q.push_back(d);
    tick(2);
    pin_strobe = 1'b0;
    tick(2);
  endtask

  // Scoreboard: every granted handshake must match the oldest expected sample
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      n_pops++;
      if (exp_q.size() == 0) chk("pop_unexpected", int'(m_axis_tdata), -1);
      else                   chk("pop_data", int'(m_axis_tdata), exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; pin_data = '0; pin_strobe = 1'b0; clr_ovf = 1'b0; m_axis_tready = 1'b0;
    tick(2);
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_tdata", int'(m_axis_tdata), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_ovf_count", int'(ovf_count), 0);
    rst_n = 1'b1;
    tick(2);

    // Single sample, latency check
    m_axis_tready = 1'b1;
    pops0 = n_pops;
    pin_data = 6'h2A;
    tick(1);
    pin_strobe = 1'b1;
    exp_q.push_back('h2A);
    tick(1); chk("lat_e0_tvalid", int'(m_axis_tvalid), 0);
    tick(1); chk("lat_e1_tvalid", int'(m_axis_tvalid), 0);
    tick(1); chk("lat_e2_tvalid", int'(m_axis_tvalid), 1);
    chk("lat_e2_tdata", int'(m_axis_tdata), 'h2A);
    chk("lat_e2_level", int'(level), 1);
    tick(1); chk("lat_e3_level", int'(level), 0);
    chk("lat_e3_tvalid", int'(m_axis_tvalid), 0);
    tick(1);
    pin_strobe = 1'b0;
    tick(4);
    chk("single_pops", n_pops - pops0, 1);

    // Backpressure then drain
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, 1'b1);
    tick(3);
    chk("bp_level", int'(level), 4);
    chk("bp_tvalid", int'(m_axis_tvalid), 1);
    chk("bp_tdata", int'(m_axis_tdata), 1);
    tick(3);
    chk("bp_tdata_held", int'(m_axis_tdata), 1);
    chk("bp_overflow", int'(overflow), 0);
    pops0 = n_pops;
    m_axis_tready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      tick(1);
      chk("drain_level", int'(level), i);
    end
    chk("drain_tvalid", int'(m_axis_tvalid), 0);
    chk("drain_pops", n_pops - pops0, 4);

    // Overflow: six strobes into a four-entry FIFO
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 6; i++) send(i, i <= 4);
    tick(2);
    chk("ovf_level", int'(level), 4);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(ovf_count), CNT_EN ? 2 : 0);
    chk("ovf_head", int'(m_axis_tdata), 1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("clr_flag", int'(overflow), 0);
    chk("clr_count", int'(ovf_count), 0);

    // Drop in the same cycle as a clear: the drop wins
    pin_data = 6'h3F;
    tick(1);
    pin_strobe = 1'b1;
    tick(2);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("clrdrop_flag", int'(overflow), 1);
    chk("clrdrop_count", int'(ovf_count), CNT_EN ? 1 : 0);
    chk("clrdrop_level", int'(level), 4);
    pin_strobe = 1'b0;
    tick(2);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    m_axis_tready = 1'b1;
    tick(5);
    chk("ovf_drained", int'(level), 0);

    // Full FIFO with push and pop in the same cycle
    m_axis_tready = 1'b0;
    for (int i = 10; i <= 13; i++) send(i, 1'b1);
    tick(2);
    chk("fullpp_pre_level", int'(level), 4);
    pin_data = fir_sample_t'(14);
    tick(1);
    pin_strobe = 1'b1;
    exp_q.push_back(14);
    tick(2);
    m_axis_tready = 1'b1;
    tick(1);
    chk("fullpp_level", int'(level), 4);
    chk("fullpp_overflow", int'(overflow), 0);
    chk("fullpp_head", int'(m_axis_tdata), 11);
    pin_strobe = 1'b0;
    tick(6);
    chk("fullpp_drained", int'(level), 0);

    // Long strobe gives exactly one push
    pops0 = n_pops;
    pin_data = 6'h33;
    tick(1);
    pin_strobe = 1'b1;
    exp_q.push_back('h33);
    tick(50);
    pin_strobe = 1'b0;
    tick(4);
    chk("long_pops", n_pops - pops0, 1);

    // Reset mid-stream flushes the FIFO immediately
    m_axis_tready = 1'b0;
    for (int i = 20; i <= 22; i++) send(i, 1'b0);
    tick(2);
    chk("mid_pre_level", int'(level), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", int'(m_axis_tvalid), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_tdata", int'(m_axis_tdata), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    m_axis_tready = 1'b1;
    pops0 = n_pops;
    send('h15, 1'b1);
    tick(3);
    chk("post_rst_pops", n_pops - pops0, 1);
    chk("post_rst_level", int'(level), 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
